// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared state encoding and default constants for motor_pwm_ramp
//
// Purpose : FSM state enum and default parameter values for the motor PWM
//           ramp block and its prescaler.
// Ports   : none (package).

package motor_pkg;

   // Drive state reported on motor_pwm_ramp.state.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      TRACK = 2'd2
   } motor_state_t;

   localparam int DEF_WIDTH     = 10;
   localparam int DEF_PERIOD    = 530;
   localparam int DEF_OFFSET    = 250;
   localparam int DEF_PRESCALE  = 16;
   localparam int DEF_RAMP_STEP = 4;

   // Counter width able to hold a value in 0..limit.
   function automatic int count_width(input int limit);
      return (limit > 1) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - divides CLOCK_50 down to a one-clock tick every PRESCALE clocks
//
// Purpose : free-running prescale counter; tick is high for the single clock
//           in which the count sits at PRESCALE-1, after which it returns to 0.
// Ports   : CLOCK_50  in   system clock
//           reset     in   synchronous, active-high reset (count -> 0)
//           tick      out  one-clock strobe, once every PRESCALE clocks

module pwm_prescaler
   import motor_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic CLOCK_50,
   input  logic reset,
   output logic tick
);

   // A one-bit counter still works for PRESCALE of 1 or 2.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + PW'(1);
      end
   end

endmodule

// File: rtl/motor_pwm_ramp.sv
// rtl/motor_pwm_ramp.sv - period-aligned PWM generator with rate-limited duty ramp-up
//
// Purpose : produces a registered PWM drive whose duty follows PWMinput plus a
//           floor OFFSET, clamped to PERIOD. Duty changes only at period
//           boundaries; rises are limited to RAMP_STEP per period when
//           MOTOR_PWM_RAMP_EN is defined, otherwise the target applies at once.
// Macro   : MOTOR_PWM_RAMP_EN - enables the rise rate limit and the RAMP state.
// Ports   : CLOCK_50      in   system clock
//           reset         in   synchronous, active-high reset
//           enable        in   drive permitted when high; low clears duty at once
//           PWMinput      in   [WIDTH] unsigned duty command
//           PWMout        out  registered PWM drive
//           period_start  out  one-clock pulse following the period wrap tick
//           duty_applied  out  [CW] duty currently in force
//           state         out  [2] IDLE / RAMP / TRACK

module motor_pwm_ramp
   import motor_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int PERIOD    = DEF_PERIOD,
   parameter int OFFSET    = DEF_OFFSET,
   parameter int PRESCALE  = DEF_PRESCALE,
   parameter int RAMP_STEP = DEF_RAMP_STEP,
   localparam int CW       = $clog2(PERIOD + 1)
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] PWMinput,
   output logic             PWMout,
   output logic             period_start,
   output logic [CW-1:0]    duty_applied,
   output logic [1:0]       state
);

`ifdef MOTOR_PWM_RAMP_EN
   localparam bit RATE_LIMIT = 1'b1;
`else
   localparam bit RATE_LIMIT = 1'b0;
`endif

   // Wide enough for PWMinput+OFFSET and duty+RAMP_STEP without overflow.
   localparam int TW = ((WIDTH > CW) ? WIDTH : CW) + 1;

   localparam logic [CW-1:0] LAST_COUNT = CW'(PERIOD - 1);
   localparam logic [TW-1:0] PERIOD_W   = TW'(PERIOD);

   logic                tick;
   logic                wrap;
   logic [CW-1:0]       counter;
   logic [CW-1:0]       counter_next;
   logic [CW-1:0]       duty_next;
   logic [CW-1:0]       target;
   logic [TW-1:0]       sum_in;
   logic [TW-1:0]       ramp_sum;
   motor_state_t        state_q;
   motor_state_t        state_next;

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .tick     (tick)
   );

   // Duty target: zero command means off; otherwise floor plus command, clamped.
   always_comb begin
      sum_in = TW'(PWMinput) + TW'(OFFSET);
      target = '0;
      if (PWMinput != '0) begin
         target = (sum_in > PERIOD_W) ? CW'(PERIOD) : CW'(sum_in);
      end
   end

   // Period counter and boundary detection.
   always_comb begin
      wrap         = tick && (counter == LAST_COUNT);
      counter_next = counter;
      if (tick) begin
         counter_next = (counter == LAST_COUNT) ? '0 : counter + CW'(1);
      end
   end

   // Duty only moves on the wrap tick so a period is never cut short.
   always_comb begin
      ramp_sum  = TW'(duty_applied) + TW'(RAMP_STEP);
      duty_next = duty_applied;
      if (wrap) begin
         if (RATE_LIMIT && (target > duty_applied)) begin
            duty_next = (ramp_sum > TW'(target)) ? target : CW'(ramp_sum);
         end else begin
            duty_next = target;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         counter      <= '0;
         period_start <= 1'b0;
         duty_applied <= '0;
         PWMout       <= 1'b0;
      end else begin
         counter      <= counter_next;
         period_start <= wrap;
         if (!enable) begin
            // Immediate shutdown; the time base keeps running so the
            // ramp restarts cleanly at the next boundary.
            duty_applied <= '0;
            PWMout       <= 1'b0;
         end else begin
            duty_applied <= duty_next;
            if (tick) begin
               // Comparing against the next count and duty keeps the output
               // aligned with the period that starts on this tick.
               PWMout <= (counter_next < duty_next);
            end
         end
      end
   end

   // State register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_next;
      end
   end

   // Next state from registered duty and live target. A duty above target
   // (command just lowered, boundary pending) is reported as TRACK.
   always_comb begin
      state_next = state_q;
      if (!enable) begin
         state_next = IDLE;
      end else if (RATE_LIMIT && (duty_applied < target)) begin
         state_next = RAMP;
      end else if (duty_applied == '0) begin
         state_next = IDLE;
      end else begin
         state_next = TRACK;
      end
   end

   assign state = state_q;

endmodule
